// File: rtl/spi_master_ctrl.sv
// SPI master controller: one word per transfer, run-time CPOL/CPHA,
// programmable sclk divider and chip-select setup/hold, all outputs registered.
module spi_master_ctrl #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned SCLK_HALF_DIV = 2,
   parameter int unsigned CS_SETUP      = 1,
   parameter int unsigned CS_HOLD       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  sclk,
   output logic                  cs_n,
   output logic                  mosi,
   input  logic                  miso
);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
   localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);
   localparam logic [7:0] DIV_LAST   = 8'(SCLK_HALF_DIV - 1);
   localparam logic [6:0] TOG_TOTAL  = 7'(2 * DATA_WIDTH);

   state_t                state, state_nx;
   logic [3:0]            phase_cnt, phase_cnt_nx;
   logic [7:0]            div_cnt, div_cnt_nx;
   logic [6:0]            tog_cnt, tog_cnt_nx;
   logic [DATA_WIDTH-1:0] tx_sh, tx_sh_nx;
   logic [DATA_WIDTH-1:0] rx_sh, rx_sh_nx;
   logic [DATA_WIDTH-1:0] rx_data_nx;
   logic                  cpha_q, cpha_q_nx;
   logic                  sclk_nx, cs_n_nx, mosi_nx, rx_valid_nx;
   logic                  tgl, leading, last_tgl;

   // State, datapath and output registers; reset forces an idle bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phase_cnt <= '0;
         div_cnt   <= '0;
         tog_cnt   <= '0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         cpha_q    <= 1'b0;
         sclk      <= 1'b0;
         cs_n      <= 1'b1;
         mosi      <= 1'b0;
         tx_ready  <= 1'b1;
         busy      <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
      end else begin
         state     <= state_nx;
         phase_cnt <= phase_cnt_nx;
         div_cnt   <= div_cnt_nx;
         tog_cnt   <= tog_cnt_nx;
         tx_sh     <= tx_sh_nx;
         rx_sh     <= rx_sh_nx;
         cpha_q    <= cpha_q_nx;
         sclk      <= sclk_nx;
         cs_n      <= cs_n_nx;
         mosi      <= mosi_nx;
         tx_ready  <= (state_nx == IDLE);
         busy      <= (state_nx != IDLE);
         rx_valid  <= rx_valid_nx;
         rx_data   <= rx_data_nx;
      end
   end

   // Next-state and next-output logic. sclk toggles are computed one cycle
   // ahead so toggle k is visible at cycle CS_SETUP + k*SCLK_HALF_DIV; with a
   // divider of 1 the first toggle is therefore launched from the last SETUP cycle.
   always_comb begin
      state_nx     = state;
      phase_cnt_nx = phase_cnt;
      div_cnt_nx   = div_cnt;
      tog_cnt_nx   = tog_cnt;
      tx_sh_nx     = tx_sh;
      rx_sh_nx     = rx_sh;
      cpha_q_nx    = cpha_q;
      sclk_nx      = sclk;
      cs_n_nx      = cs_n;
      mosi_nx      = mosi;
      rx_valid_nx  = 1'b0;
      rx_data_nx   = rx_data;
      tgl          = 1'b0;
      leading      = ~tog_cnt[0];
      last_tgl     = (tog_cnt == TOG_TOTAL - 7'd1);

      unique case (state)
         IDLE: begin
            sclk_nx = cpol;
            mosi_nx = 1'b0;
            cs_n_nx = 1'b1;
            if (tx_valid && tx_ready) begin
               state_nx     = SETUP;
               phase_cnt_nx = '0;
               div_cnt_nx   = '0;
               tog_cnt_nx   = '0;
               rx_sh_nx     = '0;
               cpha_q_nx    = cpha;
               cs_n_nx      = 1'b0;
               if (cpha) begin
                  tx_sh_nx = tx_data;
                  mosi_nx  = 1'b0;
               end else begin
                  tx_sh_nx = tx_data << 1;
                  mosi_nx  = tx_data[DATA_WIDTH-1];
               end
            end
         end
         SETUP: begin
            if (phase_cnt == SETUP_LAST) begin
               state_nx     = SHIFT;
               phase_cnt_nx = '0;
               tgl          = (div_cnt == DIV_LAST);
               div_cnt_nx   = tgl ? '0 : div_cnt + 8'd1;
            end else begin
               phase_cnt_nx = phase_cnt + 4'd1;
            end
         end
         SHIFT: begin
            if (tog_cnt == TOG_TOTAL) begin
               state_nx     = HOLD;
               phase_cnt_nx = '0;
               div_cnt_nx   = '0;
            end else begin
               tgl        = (div_cnt == DIV_LAST);
               div_cnt_nx = tgl ? '0 : div_cnt + 8'd1;
            end
         end
         HOLD: begin
            if (phase_cnt == HOLD_LAST) begin
               state_nx     = IDLE;
               phase_cnt_nx = '0;
               tog_cnt_nx   = '0;
               cs_n_nx      = 1'b1;
               sclk_nx      = cpol;
               mosi_nx      = 1'b0;
               rx_valid_nx  = 1'b1;
               rx_data_nx   = rx_sh;
            end else begin
               phase_cnt_nx = phase_cnt + 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (tgl) begin
         sclk_nx    = ~sclk;
         tog_cnt_nx = tog_cnt + 7'd1;
         if (leading == ~cpha_q)
            rx_sh_nx = {rx_sh[DATA_WIDTH-2:0], miso};
         if (cpha_q ? leading : (!leading && !last_tgl)) begin
            mosi_nx  = tx_sh[DATA_WIDTH-1];
            tx_sh_nx = tx_sh << 1;
         end
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: directed scenarios plus randomized
// transfers against a slave model and formula-based timing expectations.
module tb_spi_master_ctrl;

   localparam int DW       = 8;
   localparam int HD       = 2;
   localparam int SU       = 1;
   localparam int HO       = 1;
   localparam int NTOG     = 2 * DW;
   localparam int DONE_CYC = SU + NTOG * HD + HO + 1;

   logic          clk = 1'b0;
   logic          rst, cpol, cpha, tx_valid, tx_ready, rx_valid, busy;
   logic          sclk, cs_n, mosi, miso;
   logic [DW-1:0] tx_data, rx_data;

   int n_cmp = 0;
   int n_bad = 0;

   spi_master_ctrl #(
      .DATA_WIDTH(DW), .SCLK_HALF_DIV(HD), .CS_SETUP(SU), .CS_HOLD(HO)
   ) dut (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   // Slave model: shifts slave_word out MSB first, changing miso after the
   // edge opposite to the one the master samples on.
   logic [DW-1:0] slave_word = '0;
   logic [DW-1:0] sl_sh = '0;
   logic sl_bit = 1'b0, loop_en = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0;
   logic sl_cs_p = 1'b1, sl_sclk_p = 1'b0;

   assign miso = loop_en ? mosi : sl_bit;

   always @(negedge clk) begin
      if (cs_n !== 1'b0) begin
         sl_sh = slave_word;
      end else if (sl_cs_p === 1'b1) begin
         if (!m_cpha) begin
            sl_bit = sl_sh[DW-1];
            sl_sh  = sl_sh << 1;
         end
      end else if (sclk !== sl_sclk_p) begin
         if ((sl_sclk_p == m_cpol) == m_cpha) begin
            sl_bit = sl_sh[DW-1];
            sl_sh  = sl_sh << 1;
         end
      end
      sl_cs_p   = cs_n;
      sl_sclk_p = sclk;
   end

   // Observation results of the most recent transfer.
   int            tog_cyc[$];
   logic          tog_lvl[$];
   logic [DW-1:0] mosi_got, rx_got, inj_rx, ab_rx;
   int            mosi_n, rxv_cyc, cs_bad;
   logic          sclk_end, rxv_cs, cs_at1, inj_ready;
   logic          ab_cs, ab_sclk, ab_mosi, ab_busy;

   // Called in cycle 0 (inputs already presenting an accepted word); follows
   // the transfer cycle by cycle until rx_valid or the cycle budget runs out.
   task automatic observe(input int abort_at, input bit inj, input bit hold,
                          input logic [DW-1:0] nxt);
      logic sclk_p, lcpol, lcpha;
      lcpol = cpol;
      lcpha = cpha;
      tog_cyc.delete();
      tog_lvl.delete();
      mosi_got = '0; mosi_n = 0; rxv_cyc = -1; cs_bad = 0;
      rx_got = 'x; sclk_end = 1'bx; rxv_cs = 1'bx;
      sclk_p = sclk;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (c == 1) begin
            cs_at1 = cs_n;
            if (hold) tx_data = nxt;
            else tx_valid = 1'b0;
         end
         if (inj && c == 5) begin
            inj_ready = tx_ready;
            inj_rx    = rx_data;
            tx_valid  = 1'b1;
            tx_data   = '1;
            cpol      = ~lcpol;
            cpha      = ~lcpha;
         end
         if (inj && c == 20) begin
            tx_valid = 1'b0;
            cpol     = lcpol;
            cpha     = lcpha;
         end
         if (abort_at > 0 && c == abort_at) rst = 1'b1;
         if (abort_at > 0 && c == abort_at + 1) begin
            ab_cs = cs_n; ab_sclk = sclk; ab_mosi = mosi; ab_busy = busy; ab_rx = rx_data;
            rst = 1'b0;
         end
         if (sclk !== sclk_p) begin
            tog_cyc.push_back(c);
            tog_lvl.push_back(sclk);
            if ((sclk_p == lcpol) != lcpha) begin
               mosi_got = {mosi_got[DW-2:0], mosi};
               mosi_n++;
            end
            sclk_p = sclk;
         end
         if (rx_valid === 1'b1) begin
            rxv_cyc  = c;
            rx_got   = rx_data;
            rxv_cs   = cs_n;
            sclk_end = sclk;
            break;
         end
         if ((abort_at == 0 || c <= abort_at) && cs_n !== 1'b0) cs_bad++;
      end
   endtask

   task automatic set_mode(input logic pol, input logic pha, input logic lp,
                           input logic [DW-1:0] sw);
      cpol = pol; cpha = pha; m_cpol = pol; m_cpha = pha;
      loop_en = lp; slave_word = sw;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h77; cpol = 1'b0; cpha = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({cs_n, sclk, mosi, tx_ready, busy, rx_valid} !== 6'b100100) begin
         n_bad++;
         $display("FAIL reset_outputs cs_n/sclk/mosi/ready/busy/rxv got %b want 100100",
                  {cs_n, sclk, mosi, tx_ready, busy, rx_valid});
      end
      n_cmp++;
      if (rx_data !== 8'h00) begin
         n_bad++; $display("FAIL reset_rx_data got %h want 00", rx_data);
      end
      rst = 1'b0; tx_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || cs_n !== 1'b1) begin
         n_bad++; $display("FAIL reset_priority busy=%b cs_n=%b want 0 1", busy, cs_n);
      end
      cpol = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (sclk !== 1'b1) begin n_bad++; $display("FAIL idle_sclk_cpol1 got %b want 1", sclk); end
      cpol = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (sclk !== 1'b0) begin n_bad++; $display("FAIL idle_sclk_cpol0 got %b want 0", sclk); end
   endtask

   task automatic test_mode0_loop();
      set_mode(1'b0, 1'b0, 1'b1, '0);
      tx_data = 8'hA5; tx_valid = 1'b1;
      observe(0, 1'b0, 1'b0, '0);
      n_cmp++;
      if (mosi_got !== 8'hA5 || mosi_n != DW) begin
         n_bad++; $display("FAIL m0_mosi_bits got %h (%0d bits) want a5 (8)", mosi_got, mosi_n);
      end
      n_cmp++;
      if (tog_cyc.size() != NTOG) begin
         n_bad++; $display("FAIL m0_toggles got %0d want %0d", tog_cyc.size(), NTOG);
      end
      n_cmp++;
      if (rxv_cyc != DONE_CYC) begin
         n_bad++; $display("FAIL m0_rxv_cycle got %0d want %0d", rxv_cyc, DONE_CYC);
      end
      n_cmp++;
      if (rx_got !== 8'hA5) begin n_bad++; $display("FAIL m0_rx_data got %h want a5", rx_got); end
      n_cmp++;
      if (cs_bad != 0 || rxv_cs !== 1'b1) begin
         n_bad++; $display("FAIL m0_cs_window bad=%0d cs_at_done=%b want 0 1", cs_bad, rxv_cs);
      end
      @(negedge clk);
      n_cmp++;
      if (rx_valid !== 1'b0 || mosi !== 1'b0 || rx_data !== 8'hA5) begin
         n_bad++; $display("FAIL m0_after rxv=%b mosi=%b rx=%h want 0 0 a5", rx_valid, mosi, rx_data);
      end
   endtask

   task automatic test_mode3();
      set_mode(1'b1, 1'b1, 1'b0, 8'hC3);
      n_cmp++;
      if (sclk !== 1'b1) begin n_bad++; $display("FAIL m3_idle_sclk got %b want 1", sclk); end
      tx_data = 8'h3C; tx_valid = 1'b1;
      observe(0, 1'b0, 1'b0, '0);
      n_cmp++;
      if (tog_cyc.size() == 0 || tog_cyc[0] != SU + HD || tog_lvl[0] !== 1'b0) begin
         n_bad++; $display("FAIL m3_first_toggle cycle=%0d level=%b want %0d 0",
                           tog_cyc.size() ? tog_cyc[0] : -1, tog_lvl.size() ? tog_lvl[0] : 1'bx, SU + HD);
      end
      n_cmp++;
      if (mosi_got !== 8'h3C) begin n_bad++; $display("FAIL m3_mosi_bits got %h want 3c", mosi_got); end
      n_cmp++;
      if (rx_got !== 8'hC3) begin n_bad++; $display("FAIL m3_rx_data got %h want c3", rx_got); end
      n_cmp++;
      if (sclk_end !== 1'b1 || rxv_cyc != DONE_CYC) begin
         n_bad++; $display("FAIL m3_end sclk=%b cycle=%0d want 1 %0d", sclk_end, rxv_cyc, DONE_CYC);
      end
   endtask

   task automatic test_back_to_back();
      set_mode(1'b0, 1'b0, 1'b1, '0);
      tx_data = 8'h11; tx_valid = 1'b1;
      observe(0, 1'b0, 1'b1, 8'h22);
      n_cmp++;
      if (rx_got !== 8'h11 || rxv_cyc != DONE_CYC || rxv_cs !== 1'b1) begin
         n_bad++; $display("FAIL b2b_first rx=%h cyc=%0d cs_n=%b want 11 %0d 1", rx_got, rxv_cyc, rxv_cs, DONE_CYC);
      end
      observe(0, 1'b0, 1'b0, '0);
      n_cmp++;
      if (cs_at1 !== 1'b0) begin n_bad++; $display("FAIL b2b_cs_gap cs_n after 1 cycle got %b want 0", cs_at1); end
      n_cmp++;
      if (rx_got !== 8'h22 || mosi_got !== 8'h22 || rxv_cyc != DONE_CYC) begin
         n_bad++; $display("FAIL b2b_second rx=%h mosi=%h cyc=%0d want 22 22 %0d", rx_got, mosi_got, rxv_cyc, DONE_CYC);
      end
   endtask

   task automatic test_abort();
      set_mode(1'b0, 1'b0, 1'b1, '0);
      tx_data = 8'h96; tx_valid = 1'b1;
      observe(10, 1'b0, 1'b0, '0);
      n_cmp++;
      if ({ab_cs, ab_sclk, ab_mosi, ab_busy} !== 4'b1000 || ab_rx !== 8'h00) begin
         n_bad++; $display("FAIL abort_idle cs/sclk/mosi/busy=%b rx=%h want 1000 00",
                           {ab_cs, ab_sclk, ab_mosi, ab_busy}, ab_rx);
      end
      n_cmp++;
      if (rxv_cyc != -1) begin n_bad++; $display("FAIL abort_no_rxv got rx_valid at %0d want none", rxv_cyc); end
      tx_data = 8'h5A; tx_valid = 1'b1;
      observe(0, 1'b0, 1'b0, '0);
      n_cmp++;
      if (rx_got !== 8'h5A || rxv_cyc != DONE_CYC) begin
         n_bad++; $display("FAIL abort_next rx=%h cyc=%0d want 5a %0d", rx_got, rxv_cyc, DONE_CYC);
      end
   endtask

   task automatic test_ignore_busy();
      logic [DW-1:0] prev;
      set_mode(1'b0, 1'b0, 1'b1, '0);
      prev = rx_data;
      tx_data = 8'h81; tx_valid = 1'b1;
      observe(0, 1'b1, 1'b0, '0);
      n_cmp++;
      if (inj_ready !== 1'b0 || inj_rx !== prev) begin
         n_bad++; $display("FAIL busy_inject ready=%b rx=%h want 0 %h", inj_ready, inj_rx, prev);
      end
      n_cmp++;
      if (mosi_got !== 8'h81 || rx_got !== 8'h81 || rxv_cyc != DONE_CYC) begin
         n_bad++; $display("FAIL busy_xfer mosi=%h rx=%h cyc=%0d want 81 81 %0d", mosi_got, rx_got, rxv_cyc, DONE_CYC);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || rx_data !== 8'h81) begin
         n_bad++; $display("FAIL busy_after busy=%b rx=%h want 0 81", busy, rx_data);
      end
   endtask

   task automatic test_random();
      logic          pol, pha, lp;
      logic [DW-1:0] tw, sw, exp_rx;
      int            tbad;
      for (int i = 0; i < 16; i++) begin
         pol = 1'($urandom_range(0, 1));
         pha = 1'($urandom_range(0, 1));
         lp  = 1'($urandom_range(0, 1));
         tw  = DW'($urandom);
         sw  = DW'($urandom);
         exp_rx = lp ? tw : sw;
         set_mode(pol, pha, lp, sw);
         tx_data = tw; tx_valid = 1'b1;
         observe(0, 1'b0, 1'b0, '0);
         tbad = 0;
         if (tog_cyc.size() != NTOG) tbad++;
         else
            foreach (tog_cyc[k])
               if (tog_cyc[k] != SU + (k + 1) * HD || tog_lvl[k] !== (((k + 1) % 2 == 1) ? ~pol : pol))
                  tbad++;
         n_cmp++;
         if (tbad != 0) begin
            n_bad++; $display("FAIL rnd%0d_sclk_schedule %0d wrong of %0d toggles (want %0d)", i, tbad, tog_cyc.size(), NTOG);
         end
         n_cmp++;
         if (rx_got !== exp_rx || mosi_got !== tw) begin
            n_bad++; $display("FAIL rnd%0d_data mode=%b%b loop=%b rx=%h mosi=%h want rx=%h mosi=%h",
                              i, pol, pha, lp, rx_got, mosi_got, exp_rx, tw);
         end
         n_cmp++;
         if (rxv_cyc != DONE_CYC || sclk_end !== pol || cs_bad != 0) begin
            n_bad++; $display("FAIL rnd%0d_framing cyc=%0d sclk=%b cs_bad=%0d want %0d %b 0",
                              i, rxv_cyc, sclk_end, cs_bad, DONE_CYC, pol);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mode0_loop();
      test_mode3();
      test_back_to_back();
      test_abort();
      test_ignore_busy();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
